pipe_stage_reg: RTL and testbench
=================================

// Module: pipe_stage_reg
// PURPOSE
// - Generic pipeline stage register; replaces the per-boundary hand-written registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
// - Carries pc, Tnew, BD, ExcCode and an opaque control/data payload, plus a valid bit.
// - Uses a valid/ready handshake in place of bare stall wiring.
// - Supports an exception request (redirect to handler PC), a flush, and an optional skid slot.
// PARAMETERS
// - PAYLOAD_W  64           width of opaque payload (ALUOut, regRD2, rt/rd, control bits ...)
// - TNEW_W     2            width of Tnew field
// - RESET_PC   32'h0000_3000 out_pc value after reset
// - EXC_PC     32'h0000_4180 out_pc value loaded on req
// PORTS
// - clk          in   1          clock, rising edge
// - reset        in   1          asynchronous, active-high reset
// - req          in   1          exception request from CP0; highest synchronous priority
// - flush        in   1          kill the stage contents (branch/eret squash)
// - in_valid     in   1          upstream has an instruction
// - in_ready     out  1          stage accepts this cycle
// - in_pc        in   32         upstream pc
// - in_tnew      in   TNEW_W     upstream Tnew
// - in_bd        in   1          branch-delay-slot flag
// - in_exccode   in   5          pending exception code (0 = none)
// - in_payload   in   PAYLOAD_W  opaque payload
// - out_valid    out  1          stage holds a live instruction
// - out_ready    in   1          downstream accepts
// - out_pc / out_tnew / out_bd / out_exccode / out_payload  out  (widths as in_*)  registered stage contents
// BEHAVIOUR
// - Reset (async): out_valid=0, out_pc=RESET_PC, out_tnew=0, out_bd=0, out_exccode=0, out_payload=0; skid slot empty.
// - Synchronous priority: req > flush > normal handshake.
// - req=1: out_valid=0, out_pc=EXC_PC, all other fields 0, skid emptied. in_ready is don't-care; no transfer counted.
// - flush=1 (req=0): out_valid=0, payload/tnew/exccode=0. out_pc/out_bd take in_pc/in_bd so CP0 sees a correct EPC/BD for the bubble.
//   Skid slot is emptied.
// - Transfer in when in_valid & in_ready. Transfer out when out_valid & out_ready.
// - Latency 1 cycle, in -> out.
// - Tnew on load: out_tnew = (in_tnew==0) ? 0 : in_tnew-1 (saturating). Unchanged while held.
// - Bubble load: in_valid=0 while the stage advances -> out_valid=0 with all fields zero except out_pc/out_bd, which load from in_pc/in_bd.
// - Held (out_valid & !out_ready): all out_* are stable. Required invariant: no field changes without a transfer out.
// - Without skid: in_ready = out_ready | ~out_valid (combinational path from out_ready).
// CONFIGURATION
// - Macro PIPE_STAGE_SKID_EN.
// - Defined: adds one skid entry. in_ready = ~skid_valid is purely registered, with no out_ready -> in_ready path.
//   - An input accepted while held goes to the skid slot.
//   - On the next transfer out, the skid entry moves to out_*, with Tnew decremented at that move.
//   - Order is preserved; throughput is 1/cycle.
// - Undefined: no skid storage; in_ready is combinational as above.
// STRUCTURE
// - Package mips_pipe_pkg: RESET_PC, EXC_PC, EXCCODE_W=5, TNEW_W default, and a stage_fields_t struct {pc, tnew, bd, exccode, payload}.
// - One sub-module, pipe_skid_slot: a single register entry with valid/load/clear, instantiated only under PIPE_STAGE_SKID_EN.
// TESTING
// - Reset mid-stream: assert reset asynchronously while out_valid=1.
//   -> Same delta: out_valid=0, out_pc=32'h3000, others 0.
// - Tnew: stream in_tnew=2,1,0 with out_ready=1.
//   -> out_tnew=1,0,0 one cycle later each.
// - Backpressure: out_ready=0 for 3 cycles with in_valid=1.
//   -> out_* stable. No skid: in_ready=0. Skid: exactly one extra beat accepted, then in_ready=0; order preserved on release.
// - req while held (out_valid=1, out_ready=0, skid full).
//   -> Next edge: out_valid=0, out_pc=32'h4180, skid empty, in_ready=1.
// - req and flush in the same cycle, in_pc=32'h3010.
//   -> req wins: out_pc=32'h4180, not 32'h3010.
// - flush with in_pc=32'h3008, in_bd=1, in_exccode=5'd4.
//   -> out_valid=0, out_pc=32'h3008, out_bd=1, out_exccode=0, out_payload=0.

Source files
------------

// File: rtl/mips_pipe_pkg.sv
// Shared constants and field layout for the MIPS pipeline stage registers.
package mips_pipe_pkg;

    localparam logic [31:0] RESET_PC_DEF  = 32'h0000_3000;
    localparam logic [31:0] EXC_PC_DEF    = 32'h0000_4180;
    localparam int          EXCCODE_W     = 5;
    localparam int          TNEW_W_DEF    = 2;
    localparam int          PAYLOAD_W_DEF = 64;

    typedef struct packed {
        logic [31:0]              pc;
        logic [TNEW_W_DEF-1:0]    tnew;
        logic                     bd;
        logic [EXCCODE_W-1:0]     exccode;
        logic [PAYLOAD_W_DEF-1:0] payload;
    } stage_fields_t;

endpackage

// File: rtl/pipe_skid_slot.sv
// Single-entry holding register with valid flag; clear wins over load.
module pipe_skid_slot #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         clear,
    input  logic [W-1:0] d,
    output logic         valid,
    output logic [W-1:0] q
);

    // Slot storage and occupancy flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid <= 1'b0;
            q     <= '0;
        end else if (clear) begin
            valid <= 1'b0;
            q     <= '0;
        end else if (load) begin
            valid <= 1'b1;
            q     <= d;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register with valid/ready handshake, exception redirect and flush.
// Define PIPE_STAGE_SKID_EN to add a one-entry skid slot and a fully registered in_ready.
module pipe_stage_reg
    import mips_pipe_pkg::*;
#(
    parameter int          PAYLOAD_W = PAYLOAD_W_DEF,
    parameter int          TNEW_W    = TNEW_W_DEF,
    parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
    parameter logic [31:0] EXC_PC    = EXC_PC_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_pc,
    input  logic [TNEW_W-1:0]    in_tnew,
    input  logic                 in_bd,
    input  logic [EXCCODE_W-1:0] in_exccode,
    input  logic [PAYLOAD_W-1:0] in_payload,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_pc,
    output logic [TNEW_W-1:0]    out_tnew,
    output logic                 out_bd,
    output logic [EXCCODE_W-1:0] out_exccode,
    output logic [PAYLOAD_W-1:0] out_payload
);

    localparam int FIELDS_W = 32 + TNEW_W + 1 + EXCCODE_W + PAYLOAD_W;

    function automatic logic [TNEW_W-1:0] tnew_dec(input logic [TNEW_W-1:0] t);
        if (t == '0) begin
            tnew_dec = '0;
        end else begin
            tnew_dec = t - TNEW_W'(1);
        end
    endfunction

    logic                 advance_s;
    logic                 nxt_valid_s;
    logic [31:0]          nxt_pc_s;
    logic [TNEW_W-1:0]    nxt_tnew_s;
    logic                 nxt_bd_s;
    logic [EXCCODE_W-1:0] nxt_exccode_s;
    logic [PAYLOAD_W-1:0] nxt_payload_s;
    logic [TNEW_W-1:0]    ld_tnew_s;
    logic [EXCCODE_W-1:0] ld_exccode_s;
    logic [PAYLOAD_W-1:0] ld_payload_s;

    assign advance_s = out_ready | ~out_valid;

    // A bubble (in_valid=0) keeps only pc/bd so CP0 still sees a correct EPC/BD.
    always_comb begin
        if (in_valid) begin
            ld_tnew_s    = tnew_dec(in_tnew);
            ld_exccode_s = in_exccode;
            ld_payload_s = in_payload;
        end else begin
            ld_tnew_s    = '0;
            ld_exccode_s = '0;
            ld_payload_s = '0;
        end
    end

`ifdef PIPE_STAGE_SKID_EN
    logic                 skid_valid_s;
    logic                 skid_load_s;
    logic                 skid_clear_s;
    logic [FIELDS_W-1:0]  skid_q_s;
    logic [31:0]          sk_pc_s;
    logic [TNEW_W-1:0]    sk_tnew_s;
    logic                 sk_bd_s;
    logic [EXCCODE_W-1:0] sk_exccode_s;
    logic [PAYLOAD_W-1:0] sk_payload_s;

    assign in_ready = ~skid_valid_s;
    assign {sk_pc_s, sk_tnew_s, sk_bd_s, sk_exccode_s, sk_payload_s} = skid_q_s;

    pipe_skid_slot #(.W(FIELDS_W)) u_skid (
        .clk   (clk),
        .reset (reset),
        .load  (skid_load_s),
        .clear (skid_clear_s),
        .d     ({in_pc, in_tnew, in_bd, in_exccode, in_payload}),
        .valid (skid_valid_s),
        .q     (skid_q_s)
    );
`else
    assign in_ready = advance_s;
`endif

    // Next stage contents: req > flush > advance > hold.
    always_comb begin
        nxt_valid_s   = out_valid;
        nxt_pc_s      = out_pc;
        nxt_tnew_s    = out_tnew;
        nxt_bd_s      = out_bd;
        nxt_exccode_s = out_exccode;
        nxt_payload_s = out_payload;
`ifdef PIPE_STAGE_SKID_EN
        skid_load_s   = 1'b0;
        skid_clear_s  = 1'b0;
`endif
        if (req) begin
            nxt_valid_s   = 1'b0;
            nxt_pc_s      = EXC_PC;
            nxt_tnew_s    = '0;
            nxt_bd_s      = 1'b0;
            nxt_exccode_s = '0;
            nxt_payload_s = '0;
`ifdef PIPE_STAGE_SKID_EN
            skid_clear_s  = 1'b1;
`endif
        end else if (flush) begin
            nxt_valid_s   = 1'b0;
            nxt_pc_s      = in_pc;
            nxt_tnew_s    = '0;
            nxt_bd_s      = in_bd;
            nxt_exccode_s = '0;
            nxt_payload_s = '0;
`ifdef PIPE_STAGE_SKID_EN
            skid_clear_s  = 1'b1;
`endif
        end else if (advance_s) begin
`ifdef PIPE_STAGE_SKID_EN
            if (skid_valid_s) begin
                nxt_valid_s   = 1'b1;
                nxt_pc_s      = sk_pc_s;
                nxt_tnew_s    = tnew_dec(sk_tnew_s);
                nxt_bd_s      = sk_bd_s;
                nxt_exccode_s = sk_exccode_s;
                nxt_payload_s = sk_payload_s;
                skid_clear_s  = 1'b1;
            end else begin
                nxt_valid_s   = in_valid;
                nxt_pc_s      = in_pc;
                nxt_tnew_s    = ld_tnew_s;
                nxt_bd_s      = in_bd;
                nxt_exccode_s = ld_exccode_s;
                nxt_payload_s = ld_payload_s;
            end
`else
            nxt_valid_s   = in_valid;
            nxt_pc_s      = in_pc;
            nxt_tnew_s    = ld_tnew_s;
            nxt_bd_s      = in_bd;
            nxt_exccode_s = ld_exccode_s;
            nxt_payload_s = ld_payload_s;
`endif
        end else begin
            // Held: contents stay put; with a skid slot an accepted beat parks there.
`ifdef PIPE_STAGE_SKID_EN
            skid_load_s = in_valid & ~skid_valid_s;
`endif
        end
    end

    // Stage register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid   <= 1'b0;
            out_pc      <= RESET_PC;
            out_tnew    <= '0;
            out_bd      <= 1'b0;
            out_exccode <= '0;
            out_payload <= '0;
        end else begin
            out_valid   <= nxt_valid_s;
            out_pc      <= nxt_pc_s;
            out_tnew    <= nxt_tnew_s;
            out_bd      <= nxt_bd_s;
            out_exccode <= nxt_exccode_s;
            out_payload <= nxt_payload_s;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed scoreboard bench for pipe_stage_reg (both with and without PIPE_STAGE_SKID_EN).
module tb_pipe_stage_reg;

    localparam int PW = 64;
    localparam int TW = 2;

    logic          clk = 1'b0;
    logic          reset, req, flush, in_valid, in_ready, in_bd;
    logic          out_valid, out_ready, out_bd;
    logic [31:0]   in_pc, out_pc;
    logic [TW-1:0] in_tnew, out_tnew;
    logic [4:0]    in_exccode, out_exccode;
    logic [PW-1:0] in_payload, out_payload;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic          v;
        logic [31:0]   pc;
        logic [TW-1:0] tnew;
        logic          bd;
        logic [4:0]    exc;
        logic [PW-1:0] pay;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    pipe_stage_reg #(.PAYLOAD_W(PW), .TNEW_W(TW)) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_pc       (in_pc),
        .in_tnew     (in_tnew),
        .in_bd       (in_bd),
        .in_exccode  (in_exccode),
        .in_payload  (in_payload),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pc      (out_pc),
        .out_tnew    (out_tnew),
        .out_bd      (out_bd),
        .out_exccode (out_exccode),
        .out_payload (out_payload)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic check_out(input string tag, input exp_t e);
        check({tag, ".valid"},   64'(out_valid),   64'(e.v));
        check({tag, ".pc"},      64'(out_pc),      64'(e.pc));
        check({tag, ".tnew"},    64'(out_tnew),    64'(e.tnew));
        check({tag, ".bd"},      64'(out_bd),      64'(e.bd));
        check({tag, ".exccode"}, 64'(out_exccode), 64'(e.exc));
        check({tag, ".payload"}, out_payload,      e.pay);
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [TW-1:0] t,
                         input logic bd, input logic [4:0] exc, input logic [PW-1:0] pay);
        in_valid   = v;
        in_pc      = pc;
        in_tnew    = t;
        in_bd      = bd;
        in_exccode = exc;
        in_payload = pay;
    endtask

    task automatic push(input logic v, input logic [31:0] pc, input logic [TW-1:0] t,
                        input logic bd, input logic [4:0] exc, input logic [PW-1:0] pay);
        exp_t e;
        e = '{v: v, pc: pc, tnew: t, bd: bd, exc: exc, pay: pay};
        sb.push_back(e);
    endtask

    task automatic tick(input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s scoreboard empty observed=none expected=entry", tag);
        end else begin
            e = sb.pop_front();
            check_out(tag, e);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t rst_e;
        rst_e = '{v: 1'b0, pc: 32'h0000_3000, tnew: 2'd0, bd: 1'b0, exc: 5'd0, pay: 64'd0};

        reset = 1'b1; req = 1'b0; flush = 1'b0; out_ready = 1'b0;
        drive(1'b0, 32'h0, 2'd0, 1'b0, 5'd0, 64'd0);
        #2;
        check_out("reset", rst_e);
        reset = 1'b0;
        #1;

        // Tnew decrement on load
        out_ready = 1'b1;
        drive(1'b1, 32'h100, 2'd2, 1'b0, 5'd0, 64'hA1);
        push(1'b1, 32'h100, 2'd1, 1'b0, 5'd0, 64'hA1);
        tick("tnew2");
        drive(1'b1, 32'h104, 2'd1, 1'b1, 5'd12, 64'hA2);
        push(1'b1, 32'h104, 2'd0, 1'b1, 5'd12, 64'hA2);
        tick("tnew1");
        drive(1'b1, 32'h108, 2'd0, 1'b0, 5'd0, 64'hA3);
        push(1'b1, 32'h108, 2'd0, 1'b0, 5'd0, 64'hA3);
        tick("tnew0");

        // Backpressure for three cycles
        out_ready = 1'b0;
        drive(1'b1, 32'h10c, 2'd3, 1'b0, 5'd0, 64'hB1);
        #1;
`ifdef PIPE_STAGE_SKID_EN
        check("bp1.in_ready", 64'(in_ready), 64'd1);
`else
        check("bp1.in_ready", 64'(in_ready), 64'd0);
`endif
        push(1'b1, 32'h108, 2'd0, 1'b0, 5'd0, 64'hA3);
        tick("bp1");
`ifdef PIPE_STAGE_SKID_EN
        drive(1'b1, 32'h110, 2'd1, 1'b0, 5'd0, 64'hB2);
`endif
        #1;
        check("bp2.in_ready", 64'(in_ready), 64'd0);
        push(1'b1, 32'h108, 2'd0, 1'b0, 5'd0, 64'hA3);
        tick("bp2");
        #1;
        check("bp3.in_ready", 64'(in_ready), 64'd0);
        push(1'b1, 32'h108, 2'd0, 1'b0, 5'd0, 64'hA3);
        tick("bp3");

        // Release: order preserved
        out_ready = 1'b1;
        push(1'b1, 32'h10c, 2'd2, 1'b0, 5'd0, 64'hB1);
        tick("rel1");
        drive(1'b1, 32'h110, 2'd1, 1'b0, 5'd0, 64'hB2);
        push(1'b1, 32'h110, 2'd0, 1'b0, 5'd0, 64'hB2);
        tick("rel2");

        // req while held (skid fills in the skid build)
        out_ready = 1'b0;
        drive(1'b1, 32'h114, 2'd2, 1'b0, 5'd0, 64'hC1);
        push(1'b1, 32'h110, 2'd0, 1'b0, 5'd0, 64'hB2);
        tick("hold");
        req = 1'b1;
        push(1'b0, 32'h4180, 2'd0, 1'b0, 5'd0, 64'd0);
        tick("req_held");
        req = 1'b0;
        #1;
        check("req_held.in_ready", 64'(in_ready), 64'd1);

        // Bubble load keeps only pc/bd
        drive(1'b0, 32'h200, 2'd3, 1'b1, 5'd7, 64'hD1);
        push(1'b0, 32'h200, 2'd0, 1'b1, 5'd0, 64'd0);
        tick("bubble");

        // req beats flush
        req = 1'b1; flush = 1'b1;
        drive(1'b1, 32'h3010, 2'd1, 1'b0, 5'd3, 64'hE1);
        push(1'b0, 32'h4180, 2'd0, 1'b0, 5'd0, 64'd0);
        tick("req_flush");
        req = 1'b0;

        // flush keeps EPC/BD only
        out_ready = 1'b1;
        drive(1'b1, 32'h3008, 2'd2, 1'b1, 5'd4, 64'hF1);
        push(1'b0, 32'h3008, 2'd0, 1'b1, 5'd0, 64'd0);
        tick("flush");
        flush = 1'b0;

        // Live beat, then asynchronous reset mid-stream
        drive(1'b1, 32'h120, 2'd1, 1'b0, 5'd9, 64'hC0FFEE);
        push(1'b1, 32'h120, 2'd0, 1'b0, 5'd9, 64'hC0FFEE);
        tick("live");
        out_ready = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check_out("async_reset", rst_e);
        #3;
        reset = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
